// File: rtl/next_pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// next_pc_sequencer_if
// Purpose : Bundles the redirect/halt requests coming from decode/execute and
//           the registered next-PC/control outputs going to the PC register.
// Modports:
//   master - the next-PC sequencer (consumes requests, drives oNextPC etc.)
//   slave  - the environment (PC register plus decode/execute)
// Signals :
//   iCurPC[31:0]        current PC fed back from the PC register
//   iStall              hold PC this cycle
//   iHaltReq            halt instruction decoded
//   iResume             external resume, honoured only in HALT
//   iJump               unconditional jump valid
//   iJumpTarget[31:0]   jump destination
//   iBranchTaken        conditional branch resolved taken
//   iBranchTarget[31:0] branch destination
//   oNextPC[31:0]       next PC to the PC register
//   oHalt               PC register must hold
//   oState[1:0]         00 BOOT, 01 RUN, 10 HALT
//   oHoldCount          saturating count of cycles with oHalt=1
//   oTrap               one-cycle misalignment trap pulse
// -----------------------------------------------------------------------------
interface next_pc_if #(
   parameter int HOLD_CNT_W = 16
);
   logic [31:0]           iCurPC;
   logic                  iStall;
   logic                  iHaltReq;
   logic                  iResume;
   logic                  iJump;
   logic [31:0]           iJumpTarget;
   logic                  iBranchTaken;
   logic [31:0]           iBranchTarget;
   logic [31:0]           oNextPC;
   logic                  oHalt;
   logic [1:0]            oState;
   logic [HOLD_CNT_W-1:0] oHoldCount;
   logic                  oTrap;

   modport master (
      input  iCurPC, iStall, iHaltReq, iResume, iJump, iJumpTarget,
             iBranchTaken, iBranchTarget,
      output oNextPC, oHalt, oState, oHoldCount, oTrap
   );

   modport slave (
      output iCurPC, iStall, iHaltReq, iResume, iJump, iJumpTarget,
             iBranchTaken, iBranchTarget,
      input  oNextPC, oHalt, oState, oHoldCount, oTrap
   );
endinterface

// File: rtl/next_pc_sequencer.sv
// -----------------------------------------------------------------------------
// next_pc_sequencer
// Purpose : Producer side of the program-counter interface. Selects the next
//           PC (sequential, jump, branch, hold or halted), runs the
//           BOOT/RUN/HALT state machine and keeps a saturating count of
//           cycles spent holding. All outputs are registered.
// Ports   :
//   iClk    rising-edge clock
//   iReset  synchronous active-high reset
//   io_pc   next_pc_if.master bundle (requests in, next PC / control out)
// Optional feature:
//   NEXTPC_ALIGN_CHECK_EN - when defined, a jump or taken branch in RUN whose
//   target is not word aligned redirects to TRAP_VECTOR and pulses oTrap.
//   When undefined, targets pass through and oTrap is constant 0.
// -----------------------------------------------------------------------------
module next_pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
`ifdef NEXTPC_ALIGN_CHECK_EN
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
`endif
   parameter int          INSTR_BYTES  = 4,
   parameter int          HOLD_CNT_W   = 16
) (
   input  logic      iClk,
   input  logic      iReset,
   next_pc_if.master io_pc
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [31:0]           r_next_pc;
   logic [31:0]           w_next_pc_nxt;
   logic                  r_halt;
   logic                  w_halt_nxt;
   logic                  r_trap;
   logic                  w_trap_nxt;
   logic [HOLD_CNT_W-1:0] r_hold_cnt;
   logic [31:0]           w_seq_pc;
   logic [31:0]           w_target;

   // 32-bit add wraps naturally (FFFF_FFFC + 4 -> 0)
   assign w_seq_pc = io_pc.iCurPC + 32'(INSTR_BYTES);

   // jump has priority over a simultaneous taken branch
   assign w_target = io_pc.iJump ? io_pc.iJumpTarget : io_pc.iBranchTarget;

   always_comb begin
      w_state_nxt   = r_state;
      w_next_pc_nxt = r_next_pc;
      w_halt_nxt    = 1'b0;
      w_trap_nxt    = 1'b0;
      unique case (r_state)
         ST_BOOT: begin
            // every request is ignored for this single cycle
            w_state_nxt   = ST_RUN;
            w_next_pc_nxt = RESET_VECTOR;
         end
         ST_RUN: begin
            if (io_pc.iStall) begin
               // redirects/halt in a stall cycle are dropped, not queued
               w_halt_nxt = 1'b1;
            end else if (io_pc.iHaltReq) begin
               w_state_nxt   = ST_HALT;
               w_halt_nxt    = 1'b1;
               w_next_pc_nxt = io_pc.iCurPC;
            end else if (io_pc.iJump || io_pc.iBranchTaken) begin
`ifdef NEXTPC_ALIGN_CHECK_EN
               if (w_target[1:0] != 2'b00) begin
                  w_next_pc_nxt = TRAP_VECTOR;
                  w_trap_nxt    = 1'b1;
               end else begin
                  w_next_pc_nxt = w_target;
               end
`else
               w_next_pc_nxt = w_target;
`endif
            end else begin
               w_next_pc_nxt = w_seq_pc;
            end
         end
         ST_HALT: begin
            if (io_pc.iResume) begin
               w_state_nxt   = ST_RUN;
               w_next_pc_nxt = w_seq_pc;
            end else begin
               w_halt_nxt = 1'b1;
            end
         end
         default: begin
            // unused encoding: restart cleanly through BOOT
            w_state_nxt   = ST_BOOT;
            w_next_pc_nxt = RESET_VECTOR;
         end
      endcase
   end

   // ---- output register stage ----
   always_ff @(posedge iClk) begin
      if (iReset) begin
         r_state    <= ST_BOOT;
         r_next_pc  <= RESET_VECTOR;
         r_halt     <= 1'b0;
         r_trap     <= 1'b0;
         r_hold_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_next_pc <= w_next_pc_nxt;
         r_halt    <= w_halt_nxt;
         r_trap    <= w_trap_nxt;
         // count edges that load oHalt=1, sticking at all-ones
         if (w_halt_nxt && (r_hold_cnt != '1)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
      end
   end

   assign io_pc.oNextPC    = r_next_pc;
   assign io_pc.oHalt      = r_halt;
   assign io_pc.oState     = r_state;
   assign io_pc.oHoldCount = r_hold_cnt;
   assign io_pc.oTrap      = r_trap;

endmodule

// File: tb/tb_next_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_next_pc_sequencer
// Purpose : Directed self-checking bench for next_pc_sequencer. Inputs are
//           driven 1 time unit after a rising edge; outputs are checked 1 time
//           unit after the following rising edge. iCurPC is driven directly.
// -----------------------------------------------------------------------------
module tb_next_pc_sequencer;

   logic iClk;
   logic iReset;
   int   errors;
   int   checks;

   next_pc_if #(.HOLD_CNT_W(16)) pc_if ();

   next_pc_sequencer #(
      .RESET_VECTOR (32'h0000_0000),
      .INSTR_BYTES  (4),
      .HOLD_CNT_W   (16)
   ) dut (
      .iClk   (iClk),
      .iReset (iReset),
      .io_pc  (pc_if.master)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pc_if.iStall        = 1'b0;
      pc_if.iHaltReq      = 1'b0;
      pc_if.iResume       = 1'b0;
      pc_if.iJump         = 1'b0;
      pc_if.iJumpTarget   = 32'h0;
      pc_if.iBranchTaken  = 1'b0;
      pc_if.iBranchTarget = 32'h0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      iReset = 1'b1;
      pc_if.iCurPC = 32'h0;
      idle();

      // reset state
      tick(); tick();
      chk("rst_pc",    pc_if.oNextPC, 32'h0);
      chk("rst_halt",  {31'b0, pc_if.oHalt}, 32'h0);
      chk("rst_state", {30'b0, pc_if.oState}, 32'h0);
      chk("rst_hcnt",  {16'b0, pc_if.oHoldCount}, 32'h0);
      chk("rst_trap",  {31'b0, pc_if.oTrap}, 32'h0);

      // BOOT cycle ignores a jump request
      iReset = 1'b0;
      pc_if.iJump = 1'b1; pc_if.iJumpTarget = 32'h0000_0200;
      tick();
      chk("boot_state", {30'b0, pc_if.oState}, 32'h1);
      chk("boot_pc",    pc_if.oNextPC, 32'h0);
      chk("boot_halt",  {31'b0, pc_if.oHalt}, 32'h0);

      // sequential from 0
      idle();
      tick();
      chk("seq0_pc", pc_if.oNextPC, 32'h4);

      // jump beats branch
      pc_if.iCurPC = 32'h0000_0010;
      pc_if.iJump = 1'b1; pc_if.iJumpTarget = 32'h0000_0200;
      pc_if.iBranchTaken = 1'b1; pc_if.iBranchTarget = 32'h0000_0300;
      tick();
      chk("jmp_pc", pc_if.oNextPC, 32'h0000_0200);

      // 3-cycle stall with a branch pending: held and branch dropped
      idle();
      pc_if.iCurPC = 32'h0000_0040;
      pc_if.iStall = 1'b1;
      pc_if.iBranchTaken = 1'b1; pc_if.iBranchTarget = 32'h0000_0300;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_halt", {31'b0, pc_if.oHalt}, 32'h1);
         chk("stall_pc",   pc_if.oNextPC, 32'h0000_0200);
      end
      chk("stall_hcnt", {16'b0, pc_if.oHoldCount}, 32'd3);
      idle();
      tick();
      chk("post_stall_pc",   pc_if.oNextPC, 32'h0000_0044);
      chk("post_stall_halt", {31'b0, pc_if.oHalt}, 32'h0);
      chk("post_stall_hcnt", {16'b0, pc_if.oHoldCount}, 32'd3);

      // halt (resume in same cycle is ignored)
      pc_if.iCurPC = 32'h0000_0080;
      pc_if.iHaltReq = 1'b1; pc_if.iResume = 1'b1;
      tick();
      chk("halt_state", {30'b0, pc_if.oState}, 32'h2);
      chk("halt_halt",  {31'b0, pc_if.oHalt}, 32'h1);
      chk("halt_pc",    pc_if.oNextPC, 32'h0000_0080);
      chk("halt_hcnt",  {16'b0, pc_if.oHoldCount}, 32'd4);

      // jump ignored while halted
      idle();
      pc_if.iJump = 1'b1; pc_if.iJumpTarget = 32'h0000_0200;
      tick();
      chk("hjmp_state", {30'b0, pc_if.oState}, 32'h2);
      chk("hjmp_pc",    pc_if.oNextPC, 32'h0000_0080);
      chk("hjmp_hcnt",  {16'b0, pc_if.oHoldCount}, 32'd5);

      // resume
      idle();
      pc_if.iResume = 1'b1;
      tick();
      chk("res_state", {30'b0, pc_if.oState}, 32'h1);
      chk("res_pc",    pc_if.oNextPC, 32'h0000_0084);
      chk("res_halt",  {31'b0, pc_if.oHalt}, 32'h0);
      chk("res_hcnt",  {16'b0, pc_if.oHoldCount}, 32'd5);

      // branch alone
      idle();
      pc_if.iCurPC = 32'h0000_0084;
      pc_if.iBranchTaken = 1'b1; pc_if.iBranchTarget = 32'h0000_0300;
      tick();
      chk("br_pc", pc_if.oNextPC, 32'h0000_0300);

      // sequential wrap
      idle();
      pc_if.iCurPC = 32'hFFFF_FFFC;
      tick();
      chk("wrap_pc", pc_if.oNextPC, 32'h0000_0000);

      // misaligned jump target
      pc_if.iCurPC = 32'h0000_0010;
      pc_if.iJump = 1'b1; pc_if.iJumpTarget = 32'h0000_0202;
      tick();
`ifdef NEXTPC_ALIGN_CHECK_EN
      chk("mis_pc",   pc_if.oNextPC, 32'h0000_0100);
      chk("mis_trap", {31'b0, pc_if.oTrap}, 32'h1);
      idle();
      pc_if.iCurPC = 32'h0000_0100;
`else
      chk("mis_pc",   pc_if.oNextPC, 32'h0000_0202);
      chk("mis_trap", {31'b0, pc_if.oTrap}, 32'h0);
      idle();
      pc_if.iCurPC = 32'h0000_0100;
`endif
      chk("mis_state", {30'b0, pc_if.oState}, 32'h1);
      tick();
      chk("post_mis_pc",   pc_if.oNextPC, 32'h0000_0104);
      chk("post_mis_trap", {31'b0, pc_if.oTrap}, 32'h0);

      // reset while halted overrides everything
      pc_if.iHaltReq = 1'b1;
      tick();
      chk("pre_rst_state", {30'b0, pc_if.oState}, 32'h2);
      iReset = 1'b1;
      pc_if.iResume = 1'b1;
      tick();
      chk("hrst_state", {30'b0, pc_if.oState}, 32'h0);
      chk("hrst_pc",    pc_if.oNextPC, 32'h0);
      chk("hrst_halt",  {31'b0, pc_if.oHalt}, 32'h0);
      chk("hrst_hcnt",  {16'b0, pc_if.oHoldCount}, 32'h0);

      // hold counter saturation
      iReset = 1'b0;
      idle();
      tick();
      chk("sat_boot_state", {30'b0, pc_if.oState}, 32'h1);
      pc_if.iStall = 1'b1;
      for (int i = 0; i < 65535; i++) tick();
      chk("sat_hcnt_full", {16'b0, pc_if.oHoldCount}, 32'h0000_FFFF);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_hcnt_hold", {16'b0, pc_if.oHoldCount}, 32'h0000_FFFF);
      chk("sat_halt",      {31'b0, pc_if.oHalt}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
